alu_rr_scheduler: RTL

- Shares one alu_design instance between two requesters using round-robin arbitration.
- Each accepted request latches its operands and the 6-bit ALU control word, evaluates the ALU for one cycle, and presents a registered result (o, zr, ng) tagged with the requester id.
- A valid/ready handshake carries the result to the consumer.
- Sits between the instruction-issue logic and the shared ALU datapath.

---
 rtl/alu_sched_pkg.sv | 37 +++
 rtl/alu_design.sv | 32 +++
 rtl/rr_arb_2.sv | 20 ++
 rtl/alu_rr_scheduler.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler:
// FSM encoding, the latched operation record and the ALU control words.
package alu_sched_pkg;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Bit positions of {zx,nx,zy,ny,f,no} inside the control word.
    localparam int ZX = 5;
    localparam int NX = 4;
    localparam int ZY = 3;
    localparam int NY = 2;
    localparam int F  = 1;
    localparam int NO = 0;

    localparam logic [CTRL_W-1:0] OP_ZERO  = 6'b101010;
    localparam logic [CTRL_W-1:0] OP_ONE   = 6'b111111;
    localparam logic [CTRL_W-1:0] OP_NEG1  = 6'b111010;
    localparam logic [CTRL_W-1:0] OP_ADD   = 6'b000010;
    localparam logic [CTRL_W-1:0] OP_AND   = 6'b000000;
    localparam logic [CTRL_W-1:0] OP_XSUBY = 6'b010011;
    localparam logic [CTRL_W-1:0] OP_YSUBX = 6'b000111;

    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic [CTRL_W-1:0] s;
        logic              id;
    } op_t;

endpackage

// File: rtl/alu_design.sv
// Hack-style 16-bit ALU: optional zero/negate on each operand, add or AND,
// optional output negate. Purely combinational; carry-out is discarded.
module alu_design (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] o,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z;
    logic [15:0] x_n;
    logic [15:0] y_z;
    logic [15:0] y_n;
    logic [15:0] f_out;

    assign x_z   = zx ? 16'h0000 : x;
    assign x_n   = nx ? ~x_z : x_z;
    assign y_z   = zy ? 16'h0000 : y;
    assign y_n   = ny ? ~y_z : y_z;
    assign f_out = f ? (x_n + y_n) : (x_n & y_n);
    assign o     = no ? ~f_out : f_out;
    assign zr    = (o == 16'h0000);
    assign ng    = o[15];

endmodule

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win
// last time is granted. Purely combinational.
module rr_arb_2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_id,
    output logic gnt_valid
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one alu_design between two requesters. A winner's operation is
// latched in IDLE, evaluated in EXEC and held as a registered response in RESP.
module alu_rr_scheduler
    import alu_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic [15:0] x0,
    input  logic [15:0] y0,
    input  logic [5:0]  s0,
    input  logic        req1,
    input  logic [15:0] x1,
    input  logic [15:0] y1,
    input  logic [5:0]  s1,
    output logic        ack0,
    output logic        ack1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_o,
    output logic        rsp_zr,
    output logic        rsp_ng,
    output logic        busy
);

    state_t state_q;
    state_t state_d;

    op_t               op_q;
    op_t               op_d;
    logic              last_grant_q;
    logic              last_grant_d;
    logic              ack0_q;
    logic              ack0_d;
    logic              ack1_q;
    logic              ack1_d;
    logic              rsp_valid_q;
    logic              rsp_valid_d;
    logic              rsp_id_q;
    logic              rsp_id_d;
    logic [DATA_W-1:0] rsp_o_q;
    logic [DATA_W-1:0] rsp_o_d;
    logic              rsp_zr_q;
    logic              rsp_zr_d;
    logic              rsp_ng_q;
    logic              rsp_ng_d;

    logic              gnt_id;
    logic              gnt_valid;
    logic              accept;
    logic              capture;
    logic              release_rsp;
    logic [DATA_W-1:0] alu_o;
    logic              alu_zr;
    logic              alu_ng;

    rr_arb_2 u_arb (
        .req0      (req0),
        .req1      (req1),
        .last_grant(last_grant_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    alu_design u_alu (
        .x (op_q.x),
        .y (op_q.y),
        .zx(op_q.s[ZX]),
        .nx(op_q.s[NX]),
        .zy(op_q.s[ZY]),
        .ny(op_q.s[NY]),
        .f (op_q.s[F]),
        .no(op_q.s[NO]),
        .o (alu_o),
        .zr(alu_zr),
        .ng(alu_ng)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first; a missing branch
    // would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_valid) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Requests are only sampled in IDLE, so reqs held during EXEC/RESP are ignored.
    always_comb begin
        accept      = (state_q == IDLE) && gnt_valid;
        capture     = (state_q == EXEC);
        release_rsp = (state_q == RESP) && rsp_ready;
        busy        = (state_q != IDLE);
    end

    always_comb begin
        op_d         = op_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_o_d      = rsp_o_q;
        rsp_zr_d     = rsp_zr_q;
        rsp_ng_d     = rsp_ng_q;

        if (accept) begin
            op_d.id      = gnt_id;
            op_d.x       = gnt_id ? x1 : x0;
            op_d.y       = gnt_id ? y1 : y0;
            op_d.s       = gnt_id ? s1 : s0;
            last_grant_d = gnt_id;
            ack0_d       = ~gnt_id;
            ack1_d       = gnt_id;
        end

        if (capture) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = op_q.id;
            rsp_o_d     = alu_o;
            rsp_zr_d    = alu_zr;
            rsp_ng_d    = alu_ng;
        end else if (release_rsp) begin
            rsp_valid_d = 1'b0;
        end
    end

    // NOTE: every datapath register is reset, operands included, so a reset
    // mid-operation leaves no stale operation or response behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_o_q      <= '0;
            rsp_zr_q     <= 1'b0;
            rsp_ng_q     <= 1'b0;
        end else begin
            op_q         <= op_d;
            last_grant_q <= last_grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_o_q      <= rsp_o_d;
            rsp_zr_q     <= rsp_zr_d;
            rsp_ng_q     <= rsp_ng_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_o     = rsp_o_q;
    assign rsp_zr    = rsp_zr_q;
    assign rsp_ng    = rsp_ng_q;

endmodule
